aig_cex_search_ctrl: RTL and testbench
======================================

// Module: aig_cex_search_ctrl
// PURPOSE
//  Sequencer that drives a combinational AIG block under test (NUM_IN inputs, 1 output).
//  Sweeps input vectors over an inclusive range, issuing one vector per cycle.
//  Samples the AIG output LAT cycles after issue and reports each vector whose output
//  equals a target value (counterexample / witness search).
//  Sits between the AIG netlist and the host, with a start/done control and a valid/ready result port.
// PARAMETERS
//  NUM_IN  16  width of the AIG input vector
//  LAT     0   cycles from vec_o issue to the matching eval_i sample; legal range 0..8
// PORTS
//  clk         in   1         single clock; all logic is on the rising edge
//  rst_n       in   1         synchronous, active-low reset
//  start_i     in   1         begin a search; honoured only in IDLE
//  abort_i     in   1         terminate the current search
//  lo_i        in   NUM_IN    first vector, inclusive; latched on start
//  hi_i        in   NUM_IN    last vector, inclusive; latched on start
//  target_i    in   1         AIG output value counted as a hit; latched on start
//  cont_i      in   1         1 = resume after each reported hit, 0 = stop at first hit; latched on start
//  vec_o       out  NUM_IN    vector driven to the AIG inputs
//  vec_vld_o   out  1         vec_o is an issued vector this cycle
//  eval_i      in   1         AIG output
//  res_valid_o out  1         hit vector available
//  res_ready_i in   1         host accepts the hit
//  res_vec_o   out  NUM_IN    hit vector; held stable while res_valid_o=1
//  busy_o      out  1         state != IDLE
//  done_o      out  1         one-cycle pulse at search end
//  found_o     out  1         at least one hit since the last start
//  tested_o    out  NUM_IN+1  count of vectors evaluated and not discarded
// BEHAVIOUR
//  Reset: state IDLE; every output 0; in-flight pipe cleared.
//  FSM states: IDLE, RUN, DRAIN, REPORT, DONE.
//  IDLE:
//   - start_i with lo_i<=hi_i: latch config, clear found_o and tested_o, set next=lo -> RUN.
//   - start_i with lo_i>hi_i: clear found_o and tested_o -> DONE.
//  RUN:
//   - vec_vld_o=1, vec_o=next.
//   - Vector pushed into a LAT-deep {valid,vec} shift pipe. For LAT=0, eval_i is checked the same cycle.
//   - If next==hi, go to DRAIN; otherwise next=next+1.
//   - End test is an equality compare, so hi=2^NUM_IN-1 never wraps.
//  DRAIN: vec_vld_o=0; wait until the pipe is empty -> DONE.
//  Pipe exit (RUN or DRAIN), valid slot:
//   - tested_o increments by 1.
//   - If eval_i==target: capture res_vec, set found_o, invalidate all younger in-flight slots
//     (not counted), stop issuing -> REPORT.
//  REPORT: res_valid_o=1. On res_valid_o & res_ready_i:
//   - cont=1 and hit!=hi: next=hit+1 -> RUN.
//   - otherwise -> DONE.
//   - Resuming from hit+1 means no vector is skipped or evaluated twice.
//  DONE: done_o=1 for exactly one cycle -> IDLE. found_o and tested_o hold until the next start.
//  abort_i in RUN, DRAIN or REPORT:
//   - Next state is DONE; pipe flushed; vec_vld_o and res_valid_o are 0 from the next cycle.
//   - abort beats a same-cycle hit: no report, but tested_o still counts that returning vector.
//   - abort with res_valid_o & res_ready_i in the same cycle: the transfer completes, then DONE
//     regardless of cont.
//  start_i outside IDLE is ignored; abort_i in IDLE is ignored.
//  Reset mid-search: returns to IDLE immediately; no done_o pulse.
// TESTING
//  1 LAT=0, eval=(vec==16'h00A5), lo=0, hi=FFFF, target=1, cont=0 -> one result 00A5; tested=166; found=1; one done pulse.
//  2 lo=5, hi=4 -> done_o pulses on the cycle after start; found=0; tested=0; vec_vld_o never asserted.
//  3 LAT=3, eval=(vec[3:0]==0), lo=0, hi=3F, cont=1, res_ready=1 -> results 00,10,20,30 in order; tested=64; each vector issued and evaluated exactly once (scoreboard).
//  4 eval=0, target=1, full range -> tested=0x10000; found=0; done 65536+LAT+1 cycles after start.
//  5 abort_i at the 100th RUN cycle -> vec_vld_o=0 and done_o=1 on the next cycle; busy_o=0 one cycle later; res_valid_o never asserted.
//  6 res_ready_i low for 10 cycles in REPORT -> res_valid_o=1 and res_vec_o unchanged throughout; vec_vld_o=0; tested_o frozen.

Source files
------------

// File: rtl/aig_cex_search_ctrl.sv
// aig_cex_search_ctrl: sweeps AIG input vectors over a range and reports vectors whose output hits a target
module aig_cex_search_ctrl #(
  parameter int NUM_IN = 16,
  parameter int LAT    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [NUM_IN-1:0] lo_i,
  input  logic [NUM_IN-1:0] hi_i,
  input  logic              target_i,
  input  logic              cont_i,
  output logic [NUM_IN-1:0] vec_o,
  output logic              vec_vld_o,
  input  logic              eval_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [NUM_IN-1:0] res_vec_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_o,
  output logic [NUM_IN:0]   tested_o
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, REPORT, DONE} state_t;
  localparam int D = (LAT > 0) ? LAT : 1;
  state_t state, state_nx;
  logic [NUM_IN-1:0] hi_q, next_q, res_vec_q, exit_vec;
  logic [NUM_IN-1:0] pvec [D];
  logic [D-1:0] pv;
  logic [NUM_IN:0] tested_q;
  logic target_q, cont_q, found_q;
  logic go, issue, abt, exit_v, ev, hit, xfer, rest, at_hi;
  // next-state decode; LAT=0 evaluates the issued vector itself, so there is never anything to drain
  always_comb begin
    go = (state == IDLE) & start_i;
    issue = state == RUN;
    abt = abort_i & (state inside {RUN, DRAIN, REPORT});
    exit_v = (LAT == 0) ? issue : pv[D-1];
    exit_vec = (LAT == 0) ? next_q : pvec[D-1];
    ev = exit_v & (state inside {RUN, DRAIN});
    hit = ev & (eval_i == target_q) & ~abt;
    xfer = (state == REPORT) & res_ready_i;
    rest = |(pv << 1);
    at_hi = next_q == hi_q;
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start_i ? IDLE : (lo_i <= hi_i) ? RUN : DONE;
      RUN:     state_nx = abt ? DONE : hit ? REPORT : !at_hi ? RUN : (LAT == 0) ? DONE : DRAIN;
      DRAIN:   state_nx = abt ? DONE : hit ? REPORT : rest ? DRAIN : DONE;
      REPORT:  state_nx = abt ? DONE : !xfer ? REPORT : (cont_q && res_vec_q != hi_q) ? RUN : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // in-flight valid bits; a hit or abort discards every younger slot
  always_ff @(posedge clk) begin
    if (!rst_n || abt || hit) pv <= '0;
    else pv <= (pv << 1) | D'(issue);
  end
  // in-flight vectors travel alongside their valid bits
  always_ff @(posedge clk) begin
    pvec[0] <= next_q;
    for (int i = 1; i < D; i++) pvec[i] <= pvec[i-1];
  end
  // config latch, sweep pointer, hit capture and statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      next_q <= '0;
      res_vec_q <= '0;
      tested_q <= '0;
      target_q <= 1'b0;
      cont_q <= 1'b0;
      found_q <= 1'b0;
    end else if (go) begin
      hi_q <= hi_i;
      next_q <= lo_i;
      target_q <= target_i;
      cont_q <= cont_i;
      found_q <= 1'b0;
      tested_q <= '0;
    end else begin
      if (ev) tested_q <= tested_q + 1'b1;
      if (hit) begin
        res_vec_q <= exit_vec;
        found_q <= 1'b1;
      end
      if (issue && !at_hi) next_q <= next_q + 1'b1;
      else if (xfer) next_q <= res_vec_q + 1'b1;
    end
  end
  assign vec_o = next_q;
  assign vec_vld_o = issue;
  assign res_valid_o = state == REPORT;
  assign res_vec_o = res_vec_q;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign found_o = found_q;
  assign tested_o = tested_q;
endmodule

// File: tb/tb_aig_cex_search_ctrl.sv
// tb_aig_cex_search_ctrl: LAT=0 and LAT=3 instances driven in lockstep against a range-sweep model
module tb_aig_cex_search_ctrl;
  localparam int N = 16;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic start = 0, abort = 0, tgt = 0, cont = 0;
  logic [N-1:0] lo = 0, hi = 0;
  logic [N-1:0] vec [2], res_vec [2], hist [3];
  logic vec_vld [2], eval [2], res_valid [2], ready [2], busy [2], done [2], found [2];
  logic [N:0] tested [2];
  aig_cex_search_ctrl #(.NUM_IN(N), .LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .lo_i(lo), .hi_i(hi),
    .target_i(tgt), .cont_i(cont), .vec_o(vec[0]), .vec_vld_o(vec_vld[0]), .eval_i(eval[0]),
    .res_valid_o(res_valid[0]), .res_ready_i(ready[0]), .res_vec_o(res_vec[0]),
    .busy_o(busy[0]), .done_o(done[0]), .found_o(found[0]), .tested_o(tested[0]));
  aig_cex_search_ctrl #(.NUM_IN(N), .LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .lo_i(lo), .hi_i(hi),
    .target_i(tgt), .cont_i(cont), .vec_o(vec[1]), .vec_vld_o(vec_vld[1]), .eval_i(eval[1]),
    .res_valid_o(res_valid[1]), .res_ready_i(ready[1]), .res_vec_o(res_vec[1]),
    .busy_o(busy[1]), .done_o(done[1]), .found_o(found[1]), .tested_o(tested[1]));

  int mode = 2;
  logic [N-1:0] kc = 0, mc = 0, pc = 0;
  function automatic logic f(input logic [N-1:0] v);
    return (mode == 0) ? (v == kc) : (mode == 1) ? ((v & mc) == pc) : 1'b0;
  endfunction
  always_comb begin
    eval[0] = f(vec[0]);
    eval[1] = f(hist[2]);
  end
  int cyc = 0;
  always @(posedge clk) begin
    hist[0] <= vec[1];
    hist[1] <= hist[0];
    hist[2] <= hist[1];
    cyc <= cyc + 1;
  end

  int nerr = 0, nchk = 0;
  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s inst%0d: got %0h want %0h", nm, k, act, exp);
    end
  endtask

  logic [N-1:0] hits [$];
  int cfg_lo, cfg_hi, st_cyc;
  bit cfg_cont;
  int exp_next [2], hidx [2], exp_tested [2], done_cnt [2], done_cyc [2], nacc [2], lowc [2];
  bit exp_found [2], aborted [2], prev_rv [2], prev_acc [2], acc_b;
  logic [N-1:0] prev_rvec [2];
  logic [N:0] prev_tst [2];
  logic [N-1:0] acc_log [2][8];
  longint e;
  initial for (int k = 0; k < 2; k++) begin done_cnt[k] = 0; prev_rv[k] = 0; end

  // compare process: issue order, result order/stability and end-of-search statistics
  always @(negedge clk) if (rst_n) for (int k = 0; k < 2; k++) begin
    acc_b = res_valid[k] & ready[k];
    if (vec_vld[k]) begin
      chk("issue_vec", k, vec[k], exp_next[k]);
      chk("issue_in_range", k, exp_next[k] <= cfg_hi, 1);
      exp_next[k]++;
    end
    if (res_valid[k]) begin
      chk("no_issue_in_report", k, vec_vld[k], 0);
      if (prev_rv[k] && !prev_acc[k]) begin
        chk("res_hold", k, res_vec[k], prev_rvec[k]);
        chk("tested_frozen", k, tested[k], prev_tst[k]);
      end
    end
    if (acc_b) begin
      e = (hidx[k] < hits.size()) ? longint'(hits[hidx[k]]) : -1;
      chk("res_vec", k, res_vec[k], e);
      if (nacc[k] < 8) acc_log[k][nacc[k]] = res_vec[k];
      nacc[k]++;
      hidx[k]++;
      if (cfg_cont && res_vec[k] != cfg_hi) exp_next[k] = res_vec[k] + 1;
    end
    if (done[k]) begin
      chk("done_tested", k, tested[k], exp_tested[k]);
      chk("done_found", k, found[k], exp_found[k]);
      if (!aborted[k]) chk("all_results", k, hidx[k], hits.size());
      done_cnt[k]++;
      done_cyc[k] = cyc;
    end
    prev_rv[k] = res_valid[k];
    prev_acc[k] = acc_b;
    prev_rvec[k] = res_vec[k];
    prev_tst[k] = tested[k];
  end

  task automatic run(input int l, input int h, input bit t, input bit c, input int rm,
                     input int abort_at, input int budget);
    int d [2];
    int cnt;
    bit fin;
    cfg_lo = l;
    cfg_hi = h;
    cfg_cont = c;
    hits.delete();
    cnt = 0;
    for (int v = l; v <= h; v++) begin
      cnt++;
      if (f(16'(v)) == t) begin
        hits.push_back(16'(v));
        if (!c) break;
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      exp_next[k] = l;
      hidx[k] = 0;
      aborted[k] = 0;
      exp_tested[k] = cnt;
      exp_found[k] = hits.size() > 0;
      nacc[k] = 0;
      lowc[k] = 0;
      ready[k] = (rm == 0);
      d[k] = done_cnt[k];
    end
    lo = 16'(l);
    hi = 16'(h);
    tgt = t;
    cont = c;
    start = 1;
    st_cyc = cyc;
    fin = 0;
    for (int i = 1; i <= budget && !fin; i++) begin
      @(posedge clk); #1;
      start = 0;
      abort = 0;
      for (int k = 0; k < 2; k++) begin
        if (rm == 1) ready[k] = 1'($urandom);
        if (rm == 2) begin
          lowc[k] = res_valid[k] ? lowc[k] + 1 : 0;
          ready[k] = lowc[k] > 10;
        end
        if (i == abort_at) begin
          chk("abort_in_run", k, vec_vld[k], 1);
          aborted[k] = 1;
          exp_tested[k] = abort_at - 3 * k;
          exp_found[k] = 0;
        end
        if (abort_at > 0 && i == abort_at + 1) begin
          chk("abort_vld_low", k, vec_vld[k], 0);
          chk("abort_done", k, done[k], 1);
        end
        if (abort_at > 0 && i == abort_at + 2) chk("abort_busy_low", k, busy[k], 0);
      end
      if (i == abort_at) abort = 1;
      fin = done_cnt[0] != d[0] && done_cnt[1] != d[1];
    end
    chk("search_finished", 0, fin, 1);
    ready[0] = 0;
    ready[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("one_done_pulse", k, done_cnt[k] - d[k], 1);
  endtask

  initial begin
    ready[0] = 0;
    ready[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_vec", k, vec[k], 0);
      chk("rst_vld", k, vec_vld[k], 0);
      chk("rst_res_valid", k, res_valid[k], 0);
      chk("rst_busy_done", k, {busy[k], done[k], found[k]}, 0);
      chk("rst_tested", k, tested[k], 0);
    end
    rst_n = 1;
    mode = 0; kc = 16'h00A5;
    run(0, 16'hFFFF, 1, 0, 0, 0, 400);
    for (int k = 0; k < 2; k++) begin
      chk("t1_count", k, nacc[k], 1);
      chk("t1_vec", k, acc_log[k][0], 16'h00A5);
      chk("t1_tested", k, tested[k], 166);
      chk("t1_found", k, found[k], 1);
    end
    run(5, 4, 1, 0, 0, 0, 50);
    for (int k = 0; k < 2; k++) begin
      chk("t2_done_lat", k, done_cyc[k] - st_cyc, 1);
      chk("t2_tested", k, tested[k], 0);
      chk("t2_found", k, found[k], 0);
    end
    mode = 1; mc = 16'h000F; pc = 0;
    run(0, 16'h3F, 1, 1, 0, 0, 400);
    for (int k = 0; k < 2; k++) begin
      chk("t3_count", k, nacc[k], 4);
      for (int j = 0; j < 4; j++) chk("t3_vec", k, acc_log[k][j], 16 * j);
      chk("t3_tested", k, tested[k], 64);
    end
    mode = 2;
    run(0, 16'hFFFF, 1, 0, 0, 0, 65600);
    for (int k = 0; k < 2; k++) begin
      chk("t4_done_lat", k, done_cyc[k] - st_cyc, 65536 + 3 * k + 1);
      chk("t4_tested", k, tested[k], 17'h10000);
      chk("t4_found", k, found[k], 0);
    end
    run(0, 16'hFFFF, 1, 0, 0, 100, 400);
    for (int k = 0; k < 2; k++) chk("t5_no_result", k, nacc[k], 0);
    mode = 0; kc = 16'h0013;
    run(0, 16'h0040, 1, 1, 2, 0, 400);
    for (int k = 0; k < 2; k++) chk("t6_vec", k, acc_log[k][0], 16'h0013);
    for (int r = 0; r < 12; r++) begin
      int l, h;
      l = $urandom_range(0, 300);
      h = l + $urandom_range(0, 80);
      if ($urandom_range(0, 5) == 0 && l > 0) h = l - 1;
      mode = $urandom_range(0, 2);
      kc = 16'(l + $urandom_range(0, 90));
      mc = 16'($urandom) & 16'h00F3;
      pc = 16'($urandom) & mc;
      run(l, h, 1'($urandom), 1'($urandom), $urandom_range(0, 2), 0, 300 + (h - l + 1) * 20);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
